// File: rtl/aes_round_pipe.sv
// ============================================================================
// aes_round_pipe : pipelined AES-128 encryption round with valid/ready flow
//                  control and a sideband tag carried with each block.
// Revision 1.0
// ============================================================================
`default_nettype none

module aes_round_pipe #(
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic             in_final,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte i lives at bits [127-8i -: 8]; row = i%4, col = i/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(rw+4*c) -: 8] = SBOX[s[127-8*(rw+4*((c+rw)%4)) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] finish_round(input logic [127:0] x,
                                                  input logic [127:0] key,
                                                  input logic         fin);
        return (fin ? x : mix_columns(x)) ^ key;
    endfunction

    logic             rdy_q;
    logic             out_valid_q;
    logic [127:0]     out_state_q;
    logic [TAG_W-1:0] out_tag_q;

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_tag   = out_tag_q;

    // Holds in_ready low until the first edge after reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_round_pipe: TAG_W must be at least 1");
    end

    if (PIPE_STAGES == 1) begin : g_pipe1
        logic         w_load;
        logic [127:0] out_state_d;

        assign in_ready    = rdy_q & (~out_valid_q | out_ready);
        assign w_load      = in_valid & in_ready;
        assign out_state_d = finish_round(sub_shift(in_state), in_key, in_final);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_valid_q <= 1'b0;
                out_state_q <= '0;
                out_tag_q   <= '0;
            end else if (w_load) begin
                out_valid_q <= 1'b1;
                out_state_q <= out_state_d;
                out_tag_q   <= in_tag;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end else if (PIPE_STAGES == 2) begin : g_pipe2
        logic             a_valid_q;
        logic [127:0]     a_state_q;
        logic [127:0]     a_key_q;
        logic             a_final_q;
        logic [TAG_W-1:0] a_tag_q;
        logic             w_adv_a;
        logic             w_load_a;
        logic [127:0]     a_state_d;
        logic [127:0]     out_state_d;

        assign w_adv_a     = a_valid_q & (~out_valid_q | out_ready);
        assign in_ready    = rdy_q & (~a_valid_q | w_adv_a);
        assign w_load_a    = in_valid & in_ready;
        assign a_state_d   = sub_shift(in_state);
        assign out_state_d = finish_round(a_state_q, a_key_q, a_final_q);

        // Key and final flag ride in stage A with their own block.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_valid_q <= 1'b0;
                a_state_q <= '0;
                a_key_q   <= '0;
                a_final_q <= 1'b0;
                a_tag_q   <= '0;
            end else if (w_load_a) begin
                a_valid_q <= 1'b1;
                a_state_q <= a_state_d;
                a_key_q   <= in_key;
                a_final_q <= in_final;
                a_tag_q   <= in_tag;
            end else if (w_adv_a) begin
                a_valid_q <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_valid_q <= 1'b0;
                out_state_q <= '0;
                out_tag_q   <= '0;
            end else if (w_adv_a) begin
                out_valid_q <= 1'b1;
                out_state_q <= out_state_d;
                out_tag_q   <= a_tag_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end else begin : g_bad_stages
        $error("aes_round_pipe: PIPE_STAGES must be 1 or 2");
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
// ============================================================================
// tb_aes_round_pipe : directed + randomized bench for both pipeline depths,
//                     scoreboarded against a byte-array AES round model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_aes_round_pipe;

    localparam int TAG_W = 4;

    localparam logic [127:0] V1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] V2 = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             drv_valid = 1'b0;
    logic             drv_final = 1'b0;
    logic             drv_oready = 1'b0;
    logic [127:0]     drv_state = '0;
    logic [127:0]     drv_key = '0;
    logic [TAG_W-1:0] drv_tag = '0;
    int               sel = 0;

    logic             v1, v2, rdy1, rdy2, ov1, ov2;
    logic [127:0]     os1, os2;
    logic [TAG_W-1:0] ot1, ot2;
    logic             w_ready, w_ovalid;
    logic [127:0]     w_ostate;
    logic [TAG_W-1:0] w_otag;

    assign v1       = drv_valid && (sel == 0);
    assign v2       = drv_valid && (sel == 1);
    assign w_ready  = (sel == 1) ? rdy2 : rdy1;
    assign w_ovalid = (sel == 1) ? ov2  : ov1;
    assign w_ostate = (sel == 1) ? os2  : os1;
    assign w_otag   = (sel == 1) ? ot2  : ot1;

    aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(TAG_W)) u_p1 (
        .clk(clk), .reset(reset_n), .in_valid(v1), .in_ready(rdy1),
        .in_state(drv_state), .in_key(drv_key), .in_final(drv_final), .in_tag(drv_tag),
        .out_valid(ov1), .out_ready(drv_oready), .out_state(os1), .out_tag(ot1));

    aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(TAG_W)) u_p2 (
        .clk(clk), .reset(reset_n), .in_valid(v2), .in_ready(rdy2),
        .in_state(drv_state), .in_key(drv_key), .in_final(drv_final), .in_tag(drv_tag),
        .out_valid(ov2), .out_ready(drv_oready), .out_state(os2), .out_tag(ot2));

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       sb [256];
    logic [127:0]     exp_s_q [$];
    logic [TAG_W-1:0] exp_t_q [$];
    logic             acc, ofire;
    int               ncyc = 0;
    logic [127:0]     last_os;
    logic [TAG_W-1:0] last_ot;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc8;
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) a[i] = sb[st[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int col = 0; col < 4; col++)
                b[r+4*col] = a[r+4*((col+r)%4)];
        for (int col = 0; col < 4; col++)
            for (int r = 0; r < 4; r++) begin
                acc8 = 8'h00;
                for (int k = 0; k < 4; k++) acc8 = acc8 ^ gmul(coef[(k-r+4)%4], b[k+4*col]);
                c[r+4*col] = fin ? b[r+4*col] : acc8;
            end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = c[i] ^ key[127-8*i -: 8];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (pipe=%0d) observed=%h expected=%h", tag, sel + 1, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        acc   = drv_valid && w_ready;
        ofire = w_ovalid && drv_oready;
        if (ofire) begin
            last_os = w_ostate;
            last_ot = w_otag;
            checks++;
            assert (exp_s_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_output (pipe=%0d) observed=%h expected=none", sel + 1, w_ostate);
            end
            if (exp_s_q.size() != 0) begin
                check("out_state", w_ostate, exp_s_q.pop_front());
                check("out_tag", {124'b0, w_otag}, {124'b0, exp_t_q.pop_front()});
            end
        end
        if (acc) begin
            exp_s_q.push_back(ref_round(drv_state, drv_key, drv_final));
            exp_t_q.push_back(drv_tag);
        end
        ncyc++;
        @(negedge clk);
    endtask

    task automatic randomize_block();
        drv_state = {$urandom, $urandom, $urandom, $urandom};
        drv_key   = {$urandom, $urandom, $urandom, $urandom};
        drv_final = 1'($urandom_range(0, 1));
        drv_tag   = TAG_W'($urandom);
    endtask

    task automatic drain(input int budget);
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        for (int k = 0; k < budget && exp_s_q.size() != 0; k++) cycle();
        check("drain_empty", exp_s_q.size(), 0);
    endtask

    task automatic kat(input logic [127:0] st, input logic [127:0] key, input logic fin,
                       input logic [TAG_W-1:0] tag, input logic [127:0] res, input int want_lat);
        int lat;
        bit got;
        drv_state = st; drv_key = key; drv_final = fin; drv_tag = tag;
        drv_valid = 1'b1; drv_oready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin cycle(); got = acc; end
        check("kat_accept", got, 1);
        drv_valid = 1'b0;
        lat = 0; got = 0;
        for (int k = 0; k < 10 && !got; k++) begin cycle(); lat++; got = ofire; end
        check("kat_latency", lat, want_lat);
        check("kat_state", last_os, res);
        check("kat_tag", {124'b0, last_ot}, {124'b0, tag});
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]       inv;
        logic [127:0]     hold_s;
        logic [TAG_W-1:0] hold_t;
        int               outcyc [$];
        int               nacc, guard, spur;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        for (int p = 0; p < 2; p++) begin
            sel = p;
            exp_s_q.delete();
            exp_t_q.delete();

            // Reset state.
            drv_valid = 0; drv_oready = 0;
            reset_n = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("rst_in_ready", w_ready, 0);
            check("rst_out_valid", w_ovalid, 0);
            check("rst_out_state", w_ostate, 0);
            check("rst_out_tag", {124'b0, w_otag}, 0);
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            check("rel_in_ready_before_edge", w_ready, 0);
            @(negedge clk);
            check("rel_in_ready_after_edge", w_ready, 1);

            kat(V1, K1, 1'b0, 4'd3, R1, p + 1);
            kat(V2, K2, 1'b1, 4'd5, R2, p + 1);

            // Back-to-back streaming.
            outcyc.delete();
            drv_oready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                drv_valid = 1'b1;
                drv_state = (i % 2 == 0) ? V1 : V2;
                drv_key   = (i % 2 == 0) ? K1 : K2;
                drv_final = 1'(i % 2);
                drv_tag   = TAG_W'(i);
                cycle();
                check("stream_accept", acc, 1);
                if (ofire) outcyc.push_back(ncyc);
            end
            drv_valid = 1'b0;
            for (int k = 0; k < 10 && exp_s_q.size() != 0; k++) begin
                cycle();
                if (ofire) outcyc.push_back(ncyc);
            end
            check("stream_count", outcyc.size(), 16);
            if (outcyc.size() == 16) check("stream_span", outcyc[15] - outcyc[0], 15);

            // Backpressure window of 5 cycles mid-stream.
            for (int i = 0; i < 20; i++) begin
                drv_valid  = 1'b1;
                randomize_block();
                drv_oready = !(i >= 6 && i < 11);
                if (i == 6) begin
                    check("bp_valid_at_stall", w_ovalid, 1);
                    hold_s = w_ostate;
                    hold_t = w_otag;
                end
                if (i > 6 && i < 11) begin
                    check("bp_hold_state", w_ostate, hold_s);
                    check("bp_hold_tag", {124'b0, w_otag}, {124'b0, hold_t});
                end
                cycle();
                if (i == 10) check("bp_in_ready_low", acc, 0);
            end
            drain(20);

            // Randomized valid/ready toggling.
            nacc = 0; guard = 0;
            while (nacc < 1000 && guard < 20000) begin
                drv_valid  = ($urandom_range(0, 3) != 0);
                randomize_block();
                drv_oready = ($urandom_range(0, 3) != 0);
                cycle();
                if (acc) nacc++;
                guard++;
            end
            check("rand_accepted", nacc, 1000);
            drain(20);

            // Asynchronous reset with blocks in flight.
            drv_oready = 1'b0;
            nacc = 0;
            for (int k = 0; k < 10 && nacc < p + 1; k++) begin
                drv_valid = 1'b1;
                randomize_block();
                cycle();
                if (acc) nacc++;
            end
            drv_valid = 1'b0;
            check("inflight_count", nacc, p + 1);
            #2;
            reset_n = 1'b0;
            #1;
            check("arst_out_valid", w_ovalid, 0);
            check("arst_out_state", w_ostate, 0);
            check("arst_in_ready", w_ready, 0);
            exp_s_q.delete();
            exp_t_q.delete();
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
            #1;
            check("post_rst_in_ready", w_ready, 1);
            drv_oready = 1'b1;
            spur = 0;
            for (int k = 0; k < 6; k++) begin
                cycle();
                if (ofire) spur++;
            end
            check("post_rst_no_stale", spur, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
